image_blend_engine: RTL

IMAGE_BLEND_ENGINE -- requirements
Module: image_blend_engine

---
 rtl/image_blend_engine.sv | 129 ++++++++++++
 1 files changed

// File: rtl/image_blend_engine.sv
// Two-source weighted pixel blender: streams a frame of reads, writes (p1*w1 + p2*w2) per pixel.
// Optional macro BLEND_SATURATE_EN clamps the sum to 8'hFF instead of wrapping modulo 256.
module image_blend_engine #(
  parameter int unsigned NUM_PIXELS = 270000,
  parameter int unsigned ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [7:0]        w1,
  input  logic [7:0]        w2,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data1,
  input  logic [7:0]        rd_data2,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state, state_d;
  logic [ADDR_W-1:0] cnt_d;
  logic              load_c;

  logic [7:0]        w1_q, w2_q;
  logic              rd_vld, s1_vld;
  logic [ADDR_W-1:0] rd_tag, s1_addr;
  logic [7:0]        r1, r2;
  logic [7:0]        hi1_c, hi2_c, blend_c;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // Next-state and read-counter logic; rd_addr doubles as the read counter
  always_comb begin
    state_d = state;
    cnt_d   = rd_addr;
    load_c  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_c  = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (rd_addr == LAST_ADDR) state_d = DRAIN;
        else                      cnt_d   = rd_addr + ADDR_W'(1);
      end
      DRAIN: begin
        if (wr_en && (wr_addr == LAST_ADDR)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered control outputs and weight latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      w1_q    <= '0;
      w2_q    <= '0;
    end else begin
      rd_en   <= (state_d == RUN);
      rd_addr <= (state_d == RUN) ? cnt_d : '0;
      busy    <= (state_d != IDLE);
      done    <= (state_d == DONE);
      if (load_c) begin
        w1_q <= w1;
        w2_q <= w2;
      end
    end
  end

  assign hi1_c = 8'((16'(rd_data1) * 16'(w1_q)) >> 8);
  assign hi2_c = 8'((16'(rd_data2) * 16'(w2_q)) >> 8);

`ifdef BLEND_SATURATE_EN
  logic [8:0] sum_c;
  assign sum_c   = 9'(r1) + 9'(r2);
  assign blend_c = sum_c[8] ? 8'hFF : sum_c[7:0];
`else
  assign blend_c = r1 + r2;
`endif

  // Pipeline: read-data alignment, weighted products, then sum/write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld  <= 1'b0;
      rd_tag  <= '0;
      s1_vld  <= 1'b0;
      s1_addr <= '0;
      r1      <= '0;
      r2      <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      rd_vld  <= rd_en;
      rd_tag  <= rd_addr;
      s1_vld  <= rd_vld;
      s1_addr <= rd_tag;
      if (rd_vld) begin
        r1 <= hi1_c;
        r2 <= hi2_c;
      end
      wr_en <= s1_vld;
      if (s1_vld) begin
        wr_addr <= s1_addr;
        wr_data <= blend_c;
      end
    end
  end

endmodule
